// File: rtl/pb_event_decoder.sv
// pb_event_decoder
//   Turns the debounced push-button level into single-cycle events for the
//   flowing-LED controller: press, short press, long press and auto-repeat
//   while held. Also reports the held state and a saturating hold duration.
//
// Parameters
//   LONG_MS   hold length (clk_1ms cycles) that classifies a press as long
//   REPEAT_MS repeat_tick period after long_press while still held
//   CW        width of hold_ms and the internal repeat counter
//
// Ports
//   clk_1ms      in   1 ms tick clock, rising edge
//   rst          in   synchronous reset, active-high
//   pbreg        in   debounced button level, 1 = pressed
//   press        out  one-cycle pulse on press start
//   short_press  out  one-cycle pulse on release before LONG_MS
//   long_press   out  one-cycle pulse when the hold reaches LONG_MS
//   repeat_tick  out  one-cycle pulse every REPEAT_MS cycles after long_press
//   held         out  level, 1 while a recognised press is in progress
//   hold_ms      out  cycles held in the current/last press, saturating
module pb_event_decoder #(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int CW        = 16
) (
  input  logic          clk_1ms,
  input  logic          rst,
  input  logic          pbreg,
  output logic          press,
  output logic          short_press,
  output logic          long_press,
  output logic          repeat_tick,
  output logic          held,
  output logic [CW-1:0] hold_ms
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_LONG = 2'd2;

  localparam logic [CW-1:0] LONG_V = CW'(LONG_MS);
  localparam logic [CW-1:0] REP_V  = CW'(REPEAT_MS);
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) return v;
    else    return v + ONE_V;
  endfunction

  logic [1:0]    state;
  logic          arm;
  logic          prev_p0;
  logic [CW-1:0] rpt_cnt;
  logic [CW-1:0] hold_inc;
  logic [CW-1:0] rpt_inc;

  always_comb begin
    hold_inc = hold_ms + ONE_V;
    rpt_inc  = rpt_cnt + ONE_V;
  end

  // Stage p0: sample pbreg, advance the FSM and register every output.
  always_ff @(posedge clk_1ms) begin
    if (rst) begin
      state       <= S_IDLE;
      arm         <= 1'b0;
      prev_p0     <= 1'b0;
      rpt_cnt     <= '0;
      press       <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_tick <= 1'b0;
      held        <= 1'b0;
      hold_ms     <= '0;
    end else begin
      press       <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_tick <= 1'b0;
      prev_p0     <= pbreg;
      // A button held through reset must be seen released once before
      // any press is recognised.
      if (!pbreg) arm <= 1'b1;

      case (state)
        S_IDLE: begin
          if (arm && pbreg && !prev_p0) begin
            press   <= 1'b1;
            held    <= 1'b1;
            hold_ms <= ONE_V;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (pbreg) begin
            hold_ms <= hold_inc;
            if (hold_inc == LONG_V) begin
              long_press <= 1'b1;
              rpt_cnt    <= '0;
              state      <= S_LONG;
            end
          end else begin
            short_press <= 1'b1;
            held        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_LONG: begin
          if (pbreg) begin
            hold_ms <= sat_inc(hold_ms);
            // Repeat keeps running after hold_ms has saturated.
            if (rpt_inc == REP_V) begin
              repeat_tick <= 1'b1;
              rpt_cnt     <= '0;
            end else begin
              rpt_cnt <= rpt_inc;
            end
          end else begin
            held  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          held  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_event_decoder.sv
module tb_pb_event_decoder;

  logic clk;
  logic rst;
  logic pbreg;

  logic        press_a, short_a, long_a, rpt_a, held_a;
  logic [15:0] hold_a;
  logic        press_b, short_b, long_b, rpt_b, held_b;
  logic [3:0]  hold_b;

  pb_event_decoder #(.LONG_MS(10), .REPEAT_MS(4), .CW(16)) dut16 (
    .clk_1ms     (clk),
    .rst         (rst),
    .pbreg       (pbreg),
    .press       (press_a),
    .short_press (short_a),
    .long_press  (long_a),
    .repeat_tick (rpt_a),
    .held        (held_a),
    .hold_ms     (hold_a)
  );

  pb_event_decoder #(.LONG_MS(10), .REPEAT_MS(4), .CW(4)) dut4 (
    .clk_1ms     (clk),
    .rst         (rst),
    .pbreg       (pbreg),
    .press       (press_b),
    .short_press (short_b),
    .long_press  (long_b),
    .repeat_tick (rpt_b),
    .held        (held_b),
    .hold_ms     (hold_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  flags;   // press, short_press, long_press, repeat_tick, held
    logic [15:0] hm;      // unsaturated hold count for the CW=16 instance
  } exp_t;

  exp_t  sb_q[$];
  int    errors = 0;
  int    checks = 0;
  int    nstep  = 0;
  string tag    = "reset";

  task automatic check_out();
    exp_t        e;
    logic [20:0] o16, x16;
    logic [8:0]  o4, x4;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s step %0d scoreboard empty obs=%0d exp=>0", tag, nstep, sb_q.size());
    end
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      o16 = {press_a, short_a, long_a, rpt_a, held_a, hold_a};
      x16 = {e.flags, e.hm};
      o4  = {press_b, short_b, long_b, rpt_b, held_b, hold_b};
      x4  = {e.flags, (e.hm > 16'd15) ? 4'hF : e.hm[3:0]};
      checks++;
      assert (o16 === x16) else begin
        errors++;
        $error("FAIL %s step %0d cw16 obs=%h exp=%h", tag, nstep, o16, x16);
      end
      checks++;
      assert (o4 === x4) else begin
        errors++;
        $error("FAIL %s step %0d cw4 obs=%h exp=%h", tag, nstep, o4, x4);
      end
    end
  endtask

  task automatic step(input logic r, input logic pb, input logic p, input logic s,
                      input logic l, input logic t, input logic h, input int hm);
    exp_t e;
    rst   = r;
    pbreg = pb;
    e.flags = {p, s, l, t, h};
    e.hm    = hm[15:0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    nstep++;
    check_out();
  endtask

  initial begin
    rst   = 1'b1;
    pbreg = 1'b0;

    // Test 1: short press
    tag = "t1_reset";
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    tag = "t1_short";
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, i == 1, 0, 0, 0, 1, i);
    step(0, 0, 0, 1, 0, 0, 0, 5);
    step(0, 0, 0, 0, 0, 0, 0, 5);

    // Test 2: long press with repeat
    tag = "t2_long";
    for (int i = 1; i <= 20; i++)
      step(0, 1, i == 1, 0, i == 10, (i > 10) && ((i - 10) % 4 == 0), 1, i);
    step(0, 0, 0, 0, 0, 0, 0, 20);
    step(0, 0, 0, 0, 0, 0, 0, 20);

    // Test 3: boundary at LONG_MS-1 and LONG_MS
    tag = "t3_nine";
    for (int i = 1; i <= 9; i++) step(0, 1, i == 1, 0, 0, 0, 1, i);
    step(0, 0, 0, 1, 0, 0, 0, 9);
    tag = "t3_ten";
    for (int i = 1; i <= 10; i++) step(0, 1, i == 1, 0, i == 10, 0, 1, i);
    step(0, 0, 0, 0, 0, 0, 0, 10);
    step(0, 0, 0, 0, 0, 0, 0, 10);

    // Test 4: held through reset
    tag = "t4_rst";
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    tag = "t4_unarmed";
    for (int i = 1; i <= 30; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    tag = "t4_rearm";
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0, 0, 1);

    // Test 5: back-to-back presses
    tag = "t5_b2b";
    step(0, 1, 1, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 1, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 1, 0, 0, 0, 2);

    // Test 6: saturation (cw4 instance) and mid-press reset
    tag = "t6_sat";
    for (int i = 1; i <= 40; i++)
      step(0, 1, i == 1, 0, i == 10, (i > 10) && ((i - 10) % 4 == 0), 1, i);
    tag = "t6_midrst";
    step(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 1, 0, 0, 0, 2);

    tag = "drain";
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL %s leftover obs=%0d exp=0", tag, sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
